mmio_map: RTL and testbench

MMIO_MAP -- requirements
Module: mmio_map

---
 rtl/mmio_map.sv | 142 ++++++++++++++
 tb/tb_mmio_map.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mmio_map.sv
// Word-addressed MMIO map: general RAM, per-channel streaming input FIFOs with
// data/status ports, and output registers with one-cycle update pulses.
module mmio_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] head,
  output logic [7:0]        cnt,
  output logic              full,
  output logic              empty,
  output logic              ovf
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     count;
  logic              push_ok, pop_ok;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rp];
  assign cnt     = 8'(count);

  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + PW'(1);
      if (pop_ok)  rp <= rp + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
      // A drop while full sets overflow even if a pop frees space this cycle.
      if (push && full)  ovf <= 1'b1;
      else if (clr_ovf)  ovf <= 1'b0;
    end
endmodule

module mmio_map #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int FIFO_D = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    we,
  input  logic                    re,
  output logic [DATA_W-1:0]       rdata,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_upd
);
  localparam int MAP_SZ   = 2**ADDR_W;
  localparam int OUT_BASE = MAP_SZ - N_OUT;
  localparam int IN_BASE  = OUT_BASE - 2*N_IN;

  logic [DATA_W-1:0]             ram [IN_BASE];
  logic                          ram_sel;
  logic [N_IN-1:0]               dsel, ssel, empty, full, ovf;
  logic [N_IN-1:0][DATA_W-1:0]   head;
  logic [N_IN-1:0][7:0]          cnt;
  logic [N_OUT-1:0]              osel;
  logic [N_OUT-1:0][DATA_W-1:0]  oreg;

  assign ram_sel  = int'(addr) < IN_BASE;
  assign in_ready = ~full;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    localparam int DA = IN_BASE + 2*i;
    assign dsel[i] = int'(addr) == DA;
    assign ssel[i] = int'(addr) == DA + 1;

    mmio_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_D)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (in_valid[i]),
      .din     (in_data[i*DATA_W +: DATA_W]),
      .pop     (re && dsel[i]),
      .clr_ovf (we && ssel[i] && wdata[2]),
      .head    (head[i]),
      .cnt     (cnt[i]),
      .full    (full[i]),
      .empty   (empty[i]),
      .ovf     (ovf[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign osel[j] = int'(addr) == OUT_BASE + j;
    assign out_data[j*DATA_W +: DATA_W] = oreg[j];
  end

  always_ff @(posedge clk)
    if (we && ram_sel) ram[addr] <= wdata;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      oreg    <= '0;
      out_upd <= '0;
    end else begin
      out_upd <= we ? osel : '0;
      for (int j = 0; j < N_OUT; j++)
        if (we && osel[j]) oreg[j] <= wdata;
    end

  always_comb begin
    rdata = '0;
    if (ram_sel) rdata = ram[addr];
    for (int i = 0; i < N_IN; i++) begin
      if (dsel[i]) rdata = head[i];
      if (ssel[i]) begin
        rdata[0]    = !empty[i];
        rdata[1]    = full[i];
        rdata[2]    = ovf[i];
        rdata[15:8] = cnt[i];
      end
    end
    for (int j = 0; j < N_OUT; j++)
      if (osel[j]) rdata = oreg[j];
  end
endmodule

// File: tb/tb_mmio_map.sv
// Scoreboard bench for mmio_map at default parameters (ch0 58/59, ch1 60/61, out 62/63).
module tb_mmio_map;
  logic        clk, reset;
  logic [5:0]  addr;
  logic [31:0] wdata, rdata;
  logic        we, re;
  logic [63:0] in_data;
  logic [1:0]  in_valid, in_ready;
  logic [63:0] out_data;
  logic [1:0]  out_upd;

  mmio_map dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_upd(out_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] exp; } sb_t;
  sb_t sbq[$];
  int errs = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Drive one cycle at negedge; any expected read is queued and retired once rdata settles.
  task automatic drv(input logic [5:0] a, input logic w, input logic [31:0] wd,
                     input logic r, input logic [1:0] iv, input logic [31:0] d0,
                     input logic [31:0] d1, input bit rdchk, input logic [31:0] e,
                     input string tag);
    sb_t s;
    @(negedge clk);
    addr = a; we = w; wdata = wd; re = r; in_valid = iv; in_data = {d1, d0};
    if (rdchk) begin
      s.tag = tag; s.exp = e;
      sbq.push_back(s);
    end
    #1;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      check(s.tag, rdata, s.exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    drv(a, 1'b1, d, 1'b0, 2'b00, 0, 0, 1'b0, 0, "");
  endtask
  task automatic rd(input logic [5:0] a, input logic pop, input logic [31:0] e, input string tag);
    drv(a, 1'b0, 0, pop, 2'b00, 0, 0, 1'b1, e, tag);
  endtask
  task automatic push(input int ch, input logic [31:0] d);
    drv(6'd0, 1'b0, 0, 1'b0, (ch == 1) ? 2'b10 : 2'b01, d, d, 1'b0, 0, "");
  endtask
  task automatic idle();
    drv(6'd0, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 0, "");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; addr = 6'd59; wdata = '0; we = 1'b0; re = 1'b0;
    in_data = '0; in_valid = '0;
    #1;
    check("rst in_ready", 32'(in_ready), 32'h3);
    check("rst out_data0", out_data[31:0], 32'h0);
    check("rst out_data1", out_data[63:32], 32'h0);
    check("rst out_upd", 32'(out_upd), 32'h0);
    check("rst status0", rdata, 32'h0);
    @(negedge clk); reset = 1'b1;

    // RAM and empty-channel reads
    wr(5, 32'hDEADBEEF);
    rd(5, 0, 32'hDEADBEEF, "ram5");
    wr(0, 32'h12345678);
    wr(57, 32'hCAFEF00D);
    rd(0, 0, 32'h12345678, "ram0");
    rd(57, 0, 32'hCAFEF00D, "ram57");
    rd(58, 1, 32'h0, "ch0 empty data");
    wr(58, 32'h999);
    rd(59, 0, 32'h0, "ch0 empty status");

    // Fill and drain ch0
    push(0, 32'h11); push(0, 32'h22); push(0, 32'h33); push(0, 32'h44);
    rd(59, 0, 32'h0403, "ch0 full status");
    check("ch0 full ready", 32'(in_ready), 32'h2);
    rd(58, 1, 32'h11, "ch0 pop1");
    rd(58, 1, 32'h22, "ch0 pop2");
    rd(58, 1, 32'h33, "ch0 pop3");
    rd(58, 1, 32'h44, "ch0 pop4");
    rd(59, 0, 32'h0, "ch0 drained");

    // ch1 overflow, clear, and clear/set collision
    push(1, 32'hA1); push(1, 32'hA2); push(1, 32'hA3); push(1, 32'hA4);
    push(1, 32'h55);
    rd(61, 0, 32'h0407, "ch1 ovf");
    check("ch1 full ready", 32'(in_ready), 32'h1);
    wr(61, 32'h4);
    rd(61, 0, 32'h0403, "ch1 ovf clr");
    drv(61, 1'b1, 32'h4, 1'b0, 2'b10, 0, 32'h66, 1'b1, 32'h0403, "ch1 pre collide");
    rd(61, 0, 32'h0407, "ch1 set wins");
    wr(61, 32'h4);
    drv(60, 1'b0, 0, 1'b1, 2'b10, 0, 32'h77, 1'b1, 32'hA1, "ch1 pop on full push");
    rd(61, 0, 32'h0305, "ch1 pop+drop status");
    rd(60, 1, 32'hA2, "ch1 pop A2");
    rd(60, 1, 32'hA3, "ch1 pop A3");
    rd(60, 1, 32'hA4, "ch1 pop A4");
    rd(61, 0, 32'h0004, "ch1 empty ovf");
    wr(61, 32'h4);
    rd(61, 0, 32'h0, "ch1 clean");

    // Simultaneous push/pop with pointer wrap on ch0
    push(0, 32'h1); push(0, 32'h2);
    drv(58, 1'b0, 0, 1'b1, 2'b01, 32'h3, 0, 1'b1, 32'h1, "pp head1");
    drv(58, 1'b0, 0, 1'b1, 2'b01, 32'h4, 0, 1'b1, 32'h2, "pp head2");
    drv(58, 1'b0, 0, 1'b1, 2'b01, 32'h5, 0, 1'b1, 32'h3, "pp head3");
    rd(59, 0, 32'h0201, "pp count");
    rd(58, 1, 32'h4, "pp tail4");
    rd(58, 1, 32'h5, "pp tail5");
    rd(59, 0, 32'h0, "pp empty");

    // Output registers
    wr(63, 32'h00FF00FF);
    idle();
    check("out1 data", out_data[63:32], 32'h00FF00FF);
    check("out1 upd", 32'(out_upd), 32'h2);
    idle();
    check("out1 upd drop", 32'(out_upd), 32'h0);
    rd(63, 0, 32'h00FF00FF, "out1 read");
    wr(62, 32'h1);
    wr(62, 32'h2);
    check("out0 b2b upd1", 32'(out_upd), 32'h1);
    idle();
    check("out0 b2b upd2", 32'(out_upd), 32'h1);
    check("out0 b2b data", out_data[31:0], 32'h2);
    idle();
    check("out0 upd drop", 32'(out_upd), 32'h0);

    // Asynchronous reset mid-operation
    push(0, 32'hC1); push(0, 32'hC2); push(0, 32'hC3);
    wr(62, 32'h7);
    rd(59, 0, 32'h0301, "pre rst status");
    check("pre rst out0", out_data[31:0], 32'h7);
    check("pre rst upd", 32'(out_upd), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async status", rdata, 32'h0);
    check("async out_data", out_data[31:0] | out_data[63:32], 32'h0);
    check("async upd", 32'(out_upd), 32'h0);
    check("async ready", 32'(in_ready), 32'h3);
    @(negedge clk); reset = 1'b1;
    rd(58, 0, 32'h0, "post rst data");
    rd(62, 0, 32'h0, "post rst out0");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
